// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencing one full-adder cell built from two half adders
module halfadder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb, sr, sr_next;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             s1, c1, bit_s, c2, carry;
    logic             accept;

    halfadder u_ha1 (.a(sa[0]), .b(sb[0]), .s(s1),    .c(c1));
    halfadder u_ha2 (.a(s1),    .b(c),     .s(bit_s), .c(c2));
    assign carry = c1 | c2;

    // Shift-then-insert keeps the expression legal for WIDTH=1 as well.
    always_comb begin
        sr_next = sr >> 1;
        sr_next[WIDTH-1] = bit_s;
    end

    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa   <= '0;
            sb   <= '0;
            sr   <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            c   <= 1'b0;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sr  <= sr_next;
            c   <= carry;
            cnt <= cnt + CW'(1);
            // Result registers only move on the completing edge.
            if (cnt == LAST) begin
                sum  <= sr_next;
                cout <= carry;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1
module tb_serial_adder_ctrl;
    typedef struct {
        logic [7:0] s;
        logic       c;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0, start1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic       busy8, done8, cout8, busy1, done1, cout1;
    logic [7:0] sum8;
    logic       sum1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_done8 = 0;
    int n_done1 = 0;
    exp_t q8[$];
    exp_t q1[$];

    serial_adder_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("busy_done_exclusive8", int'(busy8 & done8), 0);
        if (done8 === 1'b1) begin
            exp_t e;
            n_done8++;
            if (q8.size() == 0) begin
                chk("done8_unexpected", 1, 0);
            end else begin
                e = q8.pop_front();
                chk("sum8", int'(sum8), int'(e.s));
                chk("cout8", int'(cout8), int'(e.c));
                chk("done8_cycle", cyc, e.cyc);
            end
        end
        if (done1 === 1'b1) begin
            exp_t e;
            n_done1++;
            if (q1.size() == 0) begin
                chk("done1_unexpected", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("sum1", int'(sum1), int'(e.s[0]));
                chk("cout1", int'(cout1), int'(e.c));
                chk("done1_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_done8(input string name);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) seen = 1;
        end
        if (!seen) chk(name, 0, 1);
    endtask

    task automatic accept8(input logic [7:0] av, input logic [7:0] bv,
                           input logic [7:0] es, input logic ec);
        @(negedge clk);
        a8 = av; b8 = bv; start8 = 1'b1;
        @(posedge clk);
        #1;
        q8.push_back('{s: es, c: ec, cyc: cyc + 8});
        start8 = 1'b0;
        a8 = ~av; b8 = ~bv;
    endtask

    task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] es, input logic ec);
        accept8(av, bv, es, ec);
        wait_done8("done8_timeout");
    endtask

    task automatic run1(input logic av, input logic bv, input logic es, input logic ec);
        bit seen = 0;
        @(negedge clk);
        a1 = av; b1 = bv; start1 = 1'b1;
        @(posedge clk);
        #1;
        q1.push_back('{s: {7'b0, es}, c: ec, cyc: cyc + 1});
        start1 = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (done1 === 1'b1) seen = 1;
        end
        if (!seen) chk("done1_timeout", 0, 1);
    endtask

    initial begin
        int nbusy;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy8", int'(busy8), 0);
        chk("rst_done8", int'(done8), 0);
        chk("rst_sum8", int'(sum8), 0);
        chk("rst_cout8", int'(cout8), 0);
        chk("rst_busy1", int'(busy1), 0);
        rst = 1'b0;

        // 0+0 with busy window length
        accept8(8'h00, 8'h00, 8'h00, 1'b0);
        nbusy = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy8 === 1'b1) nbusy++;
        end
        chk("busy_cycles", nbusy, 8);
        @(negedge clk);
        chk("done_after_busy", int'(done8), 1);

        run8(8'hFF, 8'h01, 8'h00, 1'b1);
        run8(8'h5A, 8'h3C, 8'h96, 1'b0);
        run8(8'hFF, 8'hFF, 8'hFE, 1'b1);

        // start during RUN is ignored; sum holds the previous result
        accept8(8'h10, 8'h20, 8'h30, 1'b0);
        repeat (3) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk("sum_hold_in_run", int'(sum8), 8'hFE);
        chk("cout_hold_in_run", int'(cout8), 1);
        wait_done8("ignore_timeout");
        repeat (10) @(negedge clk);
        chk("ignore_done_count", n_done8, 5);

        // back-to-back with start held high
        accept8(8'h01, 8'h02, 8'h03, 1'b0);
        start8 = 1'b1;
        a8 = 8'h80; b8 = 8'h80;
        wait_done8("b2b_first_timeout");
        @(posedge clk);
        #1;
        q8.push_back('{s: 8'h00, c: 1'b1, cyc: cyc + 8});
        start8 = 1'b0;
        @(negedge clk);
        chk("b2b_no_idle", int'(busy8), 1);
        wait_done8("b2b_second_timeout");

        // reset mid-RUN
        accept8(8'hAA, 8'h55, 8'h00, 1'b0);
        void'(q8.pop_back());
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy8), 0);
        chk("abort_done", int'(done8), 0);
        chk("abort_sum", int'(sum8), 0);
        chk("abort_cout", int'(cout8), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_no_done", n_done8, 7);
        run8(8'h01, 8'h01, 8'h02, 1'b0);

        // WIDTH=1 truth table
        run1(1'b0, 1'b0, 1'b0, 1'b0);
        run1(1'b0, 1'b1, 1'b1, 1'b0);
        run1(1'b1, 1'b0, 1'b1, 1'b0);
        run1(1'b1, 1'b1, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("total_done8", n_done8, 8);
        chk("total_done1", n_done1, 4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
